// File: rtl/rtype_instr_encoder_if.sv
// Request/memory-write bus for the R-type encoder, plus the shared encoding package.
// The encoder uses the slave modport; the requester/memory side uses master.
package rtype_instr_encoder_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  // One FIFO slot: encoded word plus end-of-program marker
  typedef struct packed {
    logic        last;
    logic [31:0] word;
  } fifo_entry_t;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  function automatic logic [31:0] encode_rtype(op_e op, logic [4:0] rd,
                                               logic [4:0] rs1, logic [4:0] rs2);
    logic [6:0] funct7;
    logic [2:0] funct3;
    funct7 = (op == OP_SUB) ? 7'b0100000 : 7'b0000000;
    case (op)
      OP_AND:  funct3 = 3'b111;
      OP_OR:   funct3 = 3'b110;
      default: funct3 = 3'b000;
    endcase
    return {funct7, rs2, rs1, funct3, rd, OPC_RTYPE};
  endfunction

endpackage

interface rtype_instr_encoder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic              req_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_last, mem_ack,
    output req_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_last, mem_ack,
    input  req_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rtype_instr_encoder.sv
// Encodes add/sub/and/or requests into RV32I R-type words, queues them, and loads them
// into instruction memory. Define RTYPE_ENC_NOP_PAD_EN to append a NOP after each program.
module rtype_instr_encoder
  import rtype_instr_encoder_pkg::*;
#(
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  rtype_instr_encoder_if.slave     bus,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
`ifdef RTYPE_ENC_NOP_PAD_EN
  localparam logic [31:0] NOP_WORD = 32'h00000013;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
`ifdef RTYPE_ENC_NOP_PAD_EN
    ,S_PAD  = 2'd3
`endif
  } state_e;

  state_e            state_q;
  fifo_entry_t       fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              done_q;
  logic              busy_q;
  logic              push;
  logic              pop;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;
  fifo_entry_t       head_next;

  // Handshake qualification and occupancy update; a full FIFO refuses even on a pop cycle
  always_comb begin
    push            = bus.req_valid && ready_q;
    pop             = (state_q == S_ISSUE) && bus.mem_ack;
    push_entry.last = bus.req_last;
    push_entry.word = encode_rtype(op_e'(bus.req_op), bus.req_rd, bus.req_rs1, bus.req_rs2);
    head            = fifo_q[rd_ptr_q];
    head_next       = fifo_q[rd_ptr_q + PTR_W'(1)];
    count_nxt       = count_q;
    if (push && !pop)      count_nxt = count_q + CNT_W'(1);
    else if (!push && pop) count_nxt = count_q - CNT_W'(1);
  end

  // FIFO storage; emptied by pointer reset, contents need no reset
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_nxt;
      ready_q <= (count_nxt != CNT_W'(DEPTH));
    end
  end

  // Write sequencer; mem_we/mem_wdata/done/busy are loaded with the values of the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q <= S_ISSUE;
            we_q    <= 1'b1;
            wdata_q <= head.word;
          end else begin
            busy_q  <= (count_nxt != '0);
          end
        end
        S_ISSUE: begin
          if (bus.mem_ack) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (head.last) begin
`ifdef RTYPE_ENC_NOP_PAD_EN
              state_q <= S_PAD;
              wdata_q <= NOP_WORD;
`else
              state_q <= S_DONE;
              we_q    <= 1'b0;
              wdata_q <= '0;
              done_q  <= 1'b1;
`endif
            end else if (count_q > CNT_W'(1)) begin
              wdata_q <= head_next.word;
            end else begin
              state_q <= S_IDLE;
              we_q    <= 1'b0;
              wdata_q <= '0;
              busy_q  <= (count_nxt != '0);
            end
          end
        end
`ifdef RTYPE_ENC_NOP_PAD_EN
        S_PAD: begin
          if (bus.mem_ack) begin
            addr_q  <= addr_q + ADDR_W'(1);
            state_q <= S_DONE;
            we_q    <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          addr_q <= BASE_ADDR;
          if (count_q != '0) begin
            state_q <= S_ISSUE;
            we_q    <= 1'b1;
            wdata_q <= head.word;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= (count_nxt != '0);
          end
        end
        default: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
          wdata_q <= '0;
          busy_q  <= (count_nxt != '0);
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign count         = count_q;

endmodule

// File: tb/tb_rtype_instr_encoder.sv
// Directed bench for rtype_instr_encoder: two instances (base 0x00 and 0xFE) share clock and reset.
module tb_rtype_instr_encoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       busy0, done0, busy1, done1;
  logic [2:0] count0, count1;
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         dcnt0 = 0;
  int         dcnt1 = 0;
  logic [39:0] wq0[$];
  logic [39:0] wq1[$];
  int          wcyc0[$];

  always #5 clk = ~clk;

  rtype_instr_encoder_if #(.ADDR_W(8)) bus0 ();
  rtype_instr_encoder_if #(.ADDR_W(8)) bus1 ();

  rtype_instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(8'h00)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .busy(busy0), .done(done0), .count(count0)
  );

  rtype_instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(8'hFE)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .busy(busy1), .done(done1), .count(count1)
  );

  // Record every accepted write and done pulse, sampled mid low phase
  always @(negedge clk) begin
    #2;
    cyc++;
    if (reset_n) begin
      if (bus0.mem_we && bus0.mem_ack) begin
        wq0.push_back({bus0.mem_addr, bus0.mem_wdata});
        wcyc0.push_back(cyc);
      end
      if (bus1.mem_we && bus1.mem_ack) wq1.push_back({bus1.mem_addr, bus1.mem_wdata});
      if (done0) dcnt0++;
      if (done1) dcnt1++;
    end
  end

  task automatic idle_req();
    bus0.req_valid = 1'b0;
    bus1.req_valid = 1'b0;
  endtask

  // Called right after a negedge; returns at the negedge after the accepting edge
  task automatic push(input int sel, input logic [1:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic last);
    int budget = 0;
    if (sel == 0) begin
      bus0.req_op = op; bus0.req_rd = rd; bus0.req_rs1 = rs1; bus0.req_rs2 = rs2;
      bus0.req_last = last; bus0.req_valid = 1'b1;
    end else begin
      bus1.req_op = op; bus1.req_rd = rd; bus1.req_rs1 = rs1; bus1.req_rs2 = rs2;
      bus1.req_last = last; bus1.req_valid = 1'b1;
    end
    while (!((sel == 0) ? bus0.req_ready : bus1.req_ready) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      n_checks++;
      $display("FAIL push_timeout: req_ready never rose on dut%0d", sel);
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input int sel, output bit ok);
    int start;
    start = (sel == 0) ? dcnt0 : dcnt1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #3;
      if (((sel == 0) ? dcnt0 : dcnt1) != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_req();
    bus0.mem_ack = 1'b0; bus1.mem_ack = 1'b0;
    bus0.req_op = '0; bus0.req_rd = '0; bus0.req_rs1 = '0; bus0.req_rs2 = '0; bus0.req_last = 1'b0;
    bus1.req_op = '0; bus1.req_rd = '0; bus1.req_rs1 = '0; bus1.req_rs2 = '0; bus1.req_last = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus0.mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", bus0.mem_we); else n_pass++;
    n_checks++; if (bus0.mem_wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 0", bus0.mem_wdata); else n_pass++;
    n_checks++; if ({done0, busy0} !== 2'b00) $display("FAIL rst_done_busy: got %b want 00", {done0, busy0}); else n_pass++;
    n_checks++; if (count0 !== 3'd0) $display("FAIL rst_count: got %0d want 0", count0); else n_pass++;
    n_checks++; if (bus0.req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus0.req_ready); else n_pass++;
    n_checks++; if (bus0.mem_addr !== 8'h00) $display("FAIL rst_addr0: got %h want 00", bus0.mem_addr); else n_pass++;
    n_checks++; if (bus1.mem_addr !== 8'hFE) $display("FAIL rst_addr1: got %h want fe", bus1.mem_addr); else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // add x3,x1,x2 with last=1 and ack tied high
  task automatic test_single();
    @(negedge clk);
    bus0.mem_ack = 1'b1;
    wq0.delete();
    push(0, 2'b00, 5'd3, 5'd1, 5'd2, 1'b1);
    idle_req();
    n_checks++; if ({bus0.mem_we, count0} !== {1'b0, 3'd1}) $display("FAIL single_early: we/count got %b/%0d want 0/1", bus0.mem_we, count0); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus0.mem_we !== 1'b1) $display("FAIL single_we: got %b want 1", bus0.mem_we); else n_pass++;
    n_checks++; if ({bus0.mem_addr, bus0.mem_wdata} !== {8'h00, 32'h002081B3}) $display("FAIL single_word: got %h/%h want 00/002081b3", bus0.mem_addr, bus0.mem_wdata); else n_pass++;
    @(negedge clk);
`ifdef RTYPE_ENC_NOP_PAD_EN
    n_checks++; if ({bus0.mem_we, bus0.mem_addr, bus0.mem_wdata} !== {1'b1, 8'h01, 32'h00000013}) $display("FAIL single_pad: got %b/%h/%h want 1/01/00000013", bus0.mem_we, bus0.mem_addr, bus0.mem_wdata); else n_pass++;
    @(negedge clk);
`endif
    n_checks++; if ({done0, bus0.mem_we} !== 2'b10) $display("FAIL single_done: done/we got %b want 10", {done0, bus0.mem_we}); else n_pass++;
    n_checks++; if (bus0.mem_wdata !== 32'h0) $display("FAIL single_wdata_idle: got %h want 0", bus0.mem_wdata); else n_pass++;
    @(negedge clk);
    n_checks++; if ({done0, busy0} !== 2'b00) $display("FAIL single_after: done/busy got %b want 00", {done0, busy0}); else n_pass++;
  endtask

  // sub x5,x6,x7 ; and x1,x2,x3 ; or x4,x4,x4 (last)
  task automatic test_program();
    bit ok;
    int d0;
    logic [39:0] exp_w [4];
    @(negedge clk);
    exp_w = '{{8'h00, 32'h407302B3}, {8'h01, 32'h003170B3}, {8'h02, 32'h00426233}, {8'h03, 32'h00000013}};
    bus0.mem_ack = 1'b1;
    wq0.delete(); wcyc0.delete();
    d0 = dcnt0;
    push(0, 2'b01, 5'd5, 5'd6, 5'd7, 1'b0);
    push(0, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0);
    push(0, 2'b11, 5'd4, 5'd4, 5'd4, 1'b1);
    idle_req();
    wait_done(0, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL prog_done_timeout: done seen %b want 1", ok); else n_pass++;
`ifdef RTYPE_ENC_NOP_PAD_EN
    n_checks++; if (wq0.size() !== 4) $display("FAIL prog_nwrites: got %0d want 4", wq0.size()); else n_pass++;
    n_checks++; if (wq0[3] !== exp_w[3]) $display("FAIL prog_pad: got %h want %h", wq0[3], exp_w[3]); else n_pass++;
`else
    n_checks++; if (wq0.size() !== 3) $display("FAIL prog_nwrites: got %0d want 3", wq0.size()); else n_pass++;
`endif
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (wq0[i] !== exp_w[i]) $display("FAIL prog_w%0d: got %h want %h", i, wq0[i], exp_w[i]); else n_pass++;
    end
    n_checks++; if ((wcyc0[1] - wcyc0[0] != 1) || (wcyc0[2] - wcyc0[1] != 1)) $display("FAIL prog_b2b: write cycles %0d,%0d,%0d want consecutive", wcyc0[0], wcyc0[1], wcyc0[2]); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (dcnt0 !== d0 + 1) $display("FAIL prog_done_count: got %0d want %0d", dcnt0 - d0, 1); else n_pass++;
  endtask

  // Ack held low: FIFO fills, 5th request stalls, head stays stable
  task automatic test_backpressure();
    bit ok;
    logic [39:0] exp_w [5];
    @(negedge clk);
    exp_w = '{{8'h00, 32'h000000B3}, {8'h01, 32'h40108133}, {8'h02, 32'h001171B3},
              {8'h03, 32'h01DF6FB3}, {8'h04, 32'h00C58533}};
    bus0.mem_ack = 1'b0;
    wq0.delete();
    push(0, 2'b00, 5'd1,  5'd0,  5'd0,  1'b0);
    push(0, 2'b01, 5'd2,  5'd1,  5'd1,  1'b0);
    push(0, 2'b10, 5'd3,  5'd2,  5'd1,  1'b0);
    push(0, 2'b11, 5'd31, 5'd30, 5'd29, 1'b0);
    n_checks++; if ({bus0.req_ready, count0} !== {1'b0, 3'd4}) $display("FAIL bp_full: ready/count got %b/%0d want 0/4", bus0.req_ready, count0); else n_pass++;
    bus0.req_op = 2'b00; bus0.req_rd = 5'd10; bus0.req_rs1 = 5'd11; bus0.req_rs2 = 5'd12;
    bus0.req_last = 1'b1; bus0.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({bus0.mem_we, bus0.req_ready, bus0.mem_addr, bus0.mem_wdata} !== {2'b10, exp_w[0]}) $display("FAIL bp_hold%0d: we/ready/addr/data got %b%b/%h/%h want 10/00/000000b3", i, bus0.mem_we, bus0.req_ready, bus0.mem_addr, bus0.mem_wdata); else n_pass++;
    end
    bus0.mem_ack = 1'b1;
    @(negedge clk);
    n_checks++; if ({bus0.req_ready, count0} !== {1'b1, 3'd3}) $display("FAIL bp_pop_no_push: ready/count got %b/%0d want 1/3", bus0.req_ready, count0); else n_pass++;
    @(negedge clk);
    idle_req();
    n_checks++; if (count0 !== 3'd3) $display("FAIL bp_push_pop: count got %0d want 3", count0); else n_pass++;
    wait_done(0, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL bp_done_timeout: done seen %b want 1", ok); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (wq0[i] !== exp_w[i]) $display("FAIL bp_w%0d: got %h want %h", i, wq0[i], exp_w[i]); else n_pass++;
    end
  endtask

  // Instance with base 0xFE: three writes wrap past the top of the address space
  task automatic test_base_wrap();
    bit ok;
    logic [39:0] exp_w [4];
    @(negedge clk);
    exp_w = '{{8'hFE, 32'h407302B3}, {8'hFF, 32'h003170B3}, {8'h00, 32'h00426233}, {8'h01, 32'h00000013}};
    bus1.mem_ack = 1'b1;
    wq1.delete();
    push(1, 2'b01, 5'd5, 5'd6, 5'd7, 1'b0);
    push(1, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0);
    push(1, 2'b11, 5'd4, 5'd4, 5'd4, 1'b1);
    idle_req();
    wait_done(1, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL wrap_done_timeout: done seen %b want 1", ok); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (wq1[i] !== exp_w[i]) $display("FAIL wrap_w%0d: got %h want %h", i, wq1[i], exp_w[i]); else n_pass++;
    end
`ifdef RTYPE_ENC_NOP_PAD_EN
    n_checks++; if (wq1[3] !== exp_w[3]) $display("FAIL wrap_pad: got %h want %h", wq1[3], exp_w[3]); else n_pass++;
`endif
    @(negedge clk);
    n_checks++; if (bus1.mem_addr !== 8'hFE) $display("FAIL wrap_reload: addr got %h want fe", bus1.mem_addr); else n_pass++;
  endtask

  // Reset asserted between clock edges while a write is pending
  task automatic test_reset_mid();
    bit ok;
    @(negedge clk);
    bus0.mem_ack = 1'b0;
    push(0, 2'b00, 5'd1, 5'd0, 5'd0, 1'b0);
    push(0, 2'b01, 5'd2, 5'd1, 5'd1, 1'b1);
    idle_req();
    n_checks++; if ({bus0.mem_we, count0} !== {1'b1, 3'd2}) $display("FAIL mid_pre: we/count got %b/%0d want 1/2", bus0.mem_we, count0); else n_pass++;
    #3 reset_n = 1'b0;
    #1;
    n_checks++; if ({bus0.mem_we, bus0.mem_wdata} !== 33'h0) $display("FAIL mid_async_we: we/wdata got %b/%h want 0/0", bus0.mem_we, bus0.mem_wdata); else n_pass++;
    n_checks++; if ({count0, bus0.req_ready, busy0, done0} !== {3'd0, 3'b100}) $display("FAIL mid_async_state: count/ready/busy/done got %0d/%b%b%b want 0/100", count0, bus0.req_ready, busy0, done0); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    bus0.mem_ack = 1'b1;
    wq0.delete();
    @(negedge clk);
    push(0, 2'b00, 5'd3, 5'd1, 5'd2, 1'b1);
    idle_req();
    wait_done(0, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL mid_done_timeout: done seen %b want 1", ok); else n_pass++;
`ifdef RTYPE_ENC_NOP_PAD_EN
    n_checks++; if (wq0.size() !== 2) $display("FAIL mid_nwrites: got %0d want 2", wq0.size()); else n_pass++;
`else
    n_checks++; if (wq0.size() !== 1) $display("FAIL mid_nwrites: got %0d want 1", wq0.size()); else n_pass++;
`endif
    n_checks++; if (wq0[0] !== {8'h00, 32'h002081B3}) $display("FAIL mid_first: got %h want 00002081b3", wq0[0]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_program();
    test_backpressure();
    test_base_wrap();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
